flag_branch_unit: RTL

- Consumer side of the ALU flag interface.
- Latches Z/N/V from the EX stage into the architectural flag register, applying per-opcode update rules.
- Evaluates B/BR conditions in ID using those flags, with an EX→ID flag bypass, and produces the branch-taken signal and target.
- Latches HLT and freezes flag state until reset.

---
 rtl/flag_branch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/flag_branch_unit.sv
// Flag register and branch resolver: latches ALU flags from EX, resolves B/BR
// conditions in ID (with EX->ID flag bypass), and tracks the sticky halt state.
module flag_branch_unit #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IMM_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [2:0]        id_cond,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [PC_W-1:0]   id_pc_plus2,
  input  logic [PC_W-1:0]   id_rs_data,
  output logic [2:0]        flags,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic              flush,
  output logic              halted
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;
  localparam logic [3:0] OpB   = 4'b1100;
  localparam logic [3:0] OpBr  = 4'b1101;
  localparam logic [3:0] OpHlt = 4'b1111;

  // Flag layout is {Z, V, N}
  logic [2:0]      flags_q;
  logic [2:0]      eff_flags;
  logic            flush_q;
  logic            halted_q;
  logic            cond_true;
  logic            is_branch;
  logic [PC_W-1:0] imm_ext;

  // Next flag value; doubles as the bypass for branch evaluation (stall ignored)
  always_comb begin
    eff_flags = flags_q;
    if (ex_valid && !halted_q) begin
      case (ex_opcode)
        OpAdd, OpSub:               eff_flags = {alu_z, alu_v, alu_n};
        OpXor, OpSll, OpSra, OpRor: eff_flags[2] = alu_z;
        default:                    ;
      endcase
    end
  end

  // Condition evaluation on the bypassed flags
  always_comb begin
    cond_true = 1'b0;
    case (id_cond)
      3'b000:  cond_true = !eff_flags[2];
      3'b001:  cond_true = eff_flags[2];
      3'b010:  cond_true = !eff_flags[2] && !eff_flags[0];
      3'b011:  cond_true = eff_flags[0];
      3'b100:  cond_true = eff_flags[2] || !eff_flags[0];
      3'b101:  cond_true = eff_flags[0] || eff_flags[2];
      3'b110:  cond_true = eff_flags[1];
      default: cond_true = 1'b1;
    endcase
  end

  assign is_branch = (id_opcode == OpB) || (id_opcode == OpBr);
  assign br_taken  = id_valid && !halted_q && is_branch && cond_true;
  assign imm_ext   = {{(PC_W - IMM_W){id_imm[IMM_W-1]}}, id_imm};

  // Branch target; B offset is in words, sum wraps modulo 2^PC_W
  always_comb begin
    br_target = '0;
    if (id_valid) begin
      if (id_opcode == OpB) begin
        br_target = id_pc_plus2 + (imm_ext << 1);
      end else if (id_opcode == OpBr) begin
        br_target = id_rs_data;
      end
    end
  end

  // Architectural state: flags, one-cycle flush pulse, sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      flush_q <= br_taken && !stall;
      if (!stall) begin
        flags_q <= eff_flags;
        if (ex_valid && (ex_opcode == OpHlt)) begin
          halted_q <= 1'b1;
        end
      end
    end
  end

  assign flags  = flags_q;
  assign flush  = flush_q;
  assign halted = halted_q;

endmodule
